// File: rtl/omsp_hmac_msg_packer.sv
// HMAC message packer: packs 8/16-bit fragments into big-endian blocks
// and appends Merkle-Damgard padding (0x80, zero fill, bit length).
module omsp_hmac_msg_packer #(
    parameter int BLOCK_BYTES = 64,
    parameter int LEN_BYTES   = 8,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hmac_reset,
    input  logic                     start_continue,
    input  logic                     data_available,
    input  logic                     data_is_long,
    input  logic [15:0]              data_in,
    output logic                     busy,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     blk_last,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     done
);

    localparam int PTR_W = $clog2(BLOCK_BYTES);
    localparam int BLK_W = 8 * BLOCK_BYTES;
    localparam int LEN_W = 8 * LEN_BYTES;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BLOCK_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_LEN  = PTR_W'(BLOCK_BYTES - LEN_BYTES);

    typedef enum logic [3:0] {
        READY,
        BYTE_HI,
        BYTE_LO,
        EMIT,
        PAD80,
        ZFILL,
        LEN,
        EMITP,
        EMITL,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic [15:0]        data_q, data_d;
    logic               pend_q, pend_d;

    logic               wr_en;
    logic [7:0]         wr_byte;
    logic               buf_clr;
    logic [LEN_W-1:0]   len_bits;
    logic [PTR_W-1:0]   len_off;

    assign len_bits = LEN_W'({cnt_q, 3'b000});
    assign len_off  = ptr_q - PTR_LEN;
    assign blk_data = buf_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        pend_d    = pend_q;
        wr_en     = 1'b0;
        wr_byte   = 8'h00;
        buf_clr   = 1'b0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        done      = 1'b0;
        busy      = ((state_q != READY) && (state_q != DONE))
                  || ((state_q == READY) && start_continue);

        unique case (state_q)
            READY: begin
                if (start_continue) begin
                    if (data_available) begin
                        data_d  = data_in;
                        state_d = data_is_long ? BYTE_HI : BYTE_LO;
                    end else begin
                        state_d = PAD80;
                    end
                end
            end
            BYTE_HI: begin
                wr_en   = 1'b1;
                wr_byte = data_q[15:8];
                ptr_d   = ptr_q + PTR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                if (ptr_q == PTR_LAST) begin
                    pend_d  = 1'b1;
                    state_d = EMIT;
                end else begin
                    state_d = BYTE_LO;
                end
            end
            BYTE_LO: begin
                wr_en   = 1'b1;
                wr_byte = data_q[7:0];
                ptr_d   = ptr_q + PTR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                if (ptr_q == PTR_LAST) begin
                    pend_d  = 1'b0;
                    state_d = EMIT;
                end else begin
                    state_d = READY;
                end
            end
            EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    buf_clr = 1'b1;
                    ptr_d   = '0;
                    pend_d  = 1'b0;
                    // A full block after the high byte still owes the low byte
                    state_d = pend_q ? BYTE_LO : READY;
                end
            end
            PAD80: begin
                wr_en   = 1'b1;
                wr_byte = 8'h80;
                ptr_d   = ptr_q + PTR_W'(1);
                state_d = (ptr_q == PTR_LAST) ? EMITP : ZFILL;
            end
            ZFILL: begin
                if (ptr_q == PTR_LEN) begin
                    state_d = LEN;
                end else begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_d = EMITP;
                    end
                end
            end
            LEN: begin
                wr_en   = 1'b1;
                wr_byte = len_bits[LEN_W-8-8*int'(len_off) +: 8];
                ptr_d   = ptr_q + PTR_W'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = EMITL;
                end
            end
            EMITP: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    buf_clr = 1'b1;
                    ptr_d   = '0;
                    state_d = ZFILL;
                end
            end
            EMITL: begin
                blk_valid = 1'b1;
                blk_last  = 1'b1;
                if (blk_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        if (buf_clr) begin
            buf_d = '0;
        end
        if (wr_en) begin
            buf_d[BLK_W-8-8*int'(ptr_q) +: 8] = wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || hmac_reset) begin
            state_q <= READY;
            ptr_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_omsp_hmac_msg_packer.sv
// Scoreboard bench for omsp_hmac_msg_packer: expected blocks are queued
// by the stimulus and compared by a monitor on each accepted block.
module tb_omsp_hmac_msg_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         hmac_reset = 1'b0;
    logic         start_continue = 1'b0;
    logic         data_available = 1'b0;
    logic         data_is_long = 1'b0;
    logic [15:0]  data_in = 16'h0;
    logic         busy;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic         blk_last;
    logic [511:0] blk_data;
    logic         done;

    always #5 clk = ~clk;

    omsp_hmac_msg_packer dut (
        .clk            (clk),
        .reset          (reset),
        .hmac_reset     (hmac_reset),
        .start_continue (start_continue),
        .data_available (data_available),
        .data_is_long   (data_is_long),
        .data_in        (data_in),
        .busy           (busy),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_last       (blk_last),
        .blk_data       (blk_data),
        .done           (done)
    );

    typedef struct {
        logic [511:0] data;
        logic         last;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  mbuf[64];
    int          mptr = 0;
    int unsigned mcount = 0;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chkb(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void push_exp(logic [511:0] d, logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endfunction

    function automatic void model_clear();
        mptr = 0;
        mcount = 0;
        for (int i = 0; i < 64; i++) mbuf[i] = 8'h00;
    endfunction

    function automatic void model_put(logic [7:0] b, logic last);
        logic [511:0] blk;
        mbuf[mptr] = b;
        mptr++;
        if (mptr == 64) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = mbuf[i];
            push_exp(blk, last);
            model_clear_buf();
        end
    endfunction

    function automatic void model_clear_buf();
        mptr = 0;
        for (int i = 0; i < 64; i++) mbuf[i] = 8'h00;
    endfunction

    function automatic void model_add(logic [7:0] b);
        mcount++;
        model_put(b, 1'b0);
    endfunction

    function automatic void model_finish();
        logic [63:0] len;
        len = {29'h0, mcount, 3'b000};
        model_put(8'h80, 1'b0);
        while (mptr != 56) model_put(8'h00, 1'b0);
        for (int k = 0; k < 8; k++) model_put(len[63-8*k -: 8], 1'b1);
    endfunction

    // Monitor: a block is consumed when valid and ready meet outside reset
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (blk_valid && blk_ready && !reset && !hmac_reset) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %h expected none", blk_data);
                end else begin
                    e = sb.pop_front();
                    chk("blk_data", blk_data, e.data);
                    chkb("blk_last", blk_last, e.last);
                end
            end
        end
    end

    task automatic do_reset();
        blk_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        model_clear();
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic send_word(logic [15:0] d, logic lng, bit use_model);
        if (use_model) begin
            if (lng) model_add(d[15:8]);
            model_add(d[7:0]);
        end
        wait_idle();
        start_continue = 1'b1;
        data_available = 1'b1;
        data_is_long = lng;
        data_in = d;
        @(posedge clk);
        #1 start_continue = 1'b0;
        data_available = 1'b0;
    endtask

    task automatic finalize(bit use_model);
        if (use_model) model_finish();
        wait_idle();
        start_continue = 1'b1;
        data_available = 1'b0;
        @(posedge clk);
        #1 start_continue = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!blk_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkb("valid_seen", blk_valid, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chkb("done", done, 1'b1);
        chkb("done_busy", busy, 1'b0);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] snap;

        // Reset state
        do_reset();
        @(negedge clk);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_valid", blk_valid, 1'b0);
        chkb("rst_done", done, 1'b0);

        // Empty message
        push_exp({8'h80, 504'h0}, 1'b1);
        finalize(1'b0);
        wait_done();
        @(negedge clk);
        start_continue = 1'b1;
        data_available = 1'b1;
        #1 chkb("done_req_busy", busy, 1'b0);
        @(posedge clk);
        #1 start_continue = 1'b0;
        data_available = 1'b0;
        @(negedge clk);
        chkb("done_hold", done, 1'b1);
        chkb("done_no_valid", blk_valid, 1'b0);

        // Mixed long/short words
        do_reset();
        push_exp({64'h123456789ABC0180, 384'h0, 64'h38}, 1'b1);
        send_word(16'h1234, 1'b1, 1'b0);
        send_word(16'h5678, 1'b1, 1'b0);
        send_word(16'h9ABC, 1'b1, 1'b0);
        send_word(16'h0001, 1'b0, 1'b0);
        finalize(1'b0);
        wait_done();

        // 56 bytes: padding spills into a second block
        do_reset();
        for (int i = 0; i < 28; i++)
            send_word(16'((2 * i) << 8 | (2 * i + 1)), 1'b1, 1'b1);
        finalize(1'b1);
        wait_done();

        // 64 bytes with a stalled first block
        do_reset();
        blk_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            send_word(16'((8'hA0 + i) << 8 | (8'h40 + i)), 1'b1, 1'b1);
        wait_valid();
        snap = blk_data;
        repeat (10) begin
            @(negedge clk);
            chk("stall_data", blk_data, snap);
            chkb("stall_busy", busy, 1'b1);
            chkb("stall_valid", blk_valid, 1'b1);
        end
        @(posedge clk);
        #1 blk_ready = 1'b1;
        finalize(1'b1);
        wait_done();

        // Soft clear colliding with acceptance
        do_reset();
        blk_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            send_word(16'(16'h1111 * (i + 1)), 1'b1, 1'b1);
        wait_valid();
        @(posedge clk);
        #1 hmac_reset = 1'b1;
        blk_ready = 1'b1;
        @(posedge clk);
        #1 hmac_reset = 1'b0;
        sb.delete();
        model_clear();
        @(negedge clk);
        chkb("hrst_valid", blk_valid, 1'b0);
        chkb("hrst_busy", busy, 1'b0);
        send_word(16'h00AB, 1'b0, 1'b1);
        finalize(1'b1);
        wait_done();

        // Request while busy in BYTE_HI is dropped
        do_reset();
        send_word(16'hCAFE, 1'b1, 1'b1);
        start_continue = 1'b1;
        data_available = 1'b1;
        data_is_long = 1'b1;
        data_in = 16'hFFFF;
        @(posedge clk);
        #1 start_continue = 1'b0;
        data_available = 1'b0;
        finalize(1'b1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
